// File: rtl/delta_output_sram_arbiter_pkg.sv
// Shared definitions for the Output SRAM arbiter: FSM state encoding and default sizing.
package delta_pkg;

  localparam int REQ_NUM_DEF = 3;
  localparam int TIMEOUT_DEF = 255;
  localparam int WDOG_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RELEASE = 2'b10
  } state_t;

endpackage

// File: rtl/delta_output_sram_arbiter_if.sv
// Output SRAM port bundle: strobes, addresses and data toward the SRAM, completions back.
interface delta_output_sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic              Output_SRAM_w_en;
  logic              Output_SRAM_r_en;
  logic [ADDR_W-1:0] Output_SRAM_w_addr;
  logic [ADDR_W-1:0] Output_SRAM_r_addr;
  logic [DATA_W-1:0] Output_SRAM_w_d;
  logic [DATA_W-1:0] Output_SRAM_r_d;
  logic              Output_SRAM_d_ready;
  logic              Output_SRAM_w_done;

  modport master (
    output Output_SRAM_w_en, Output_SRAM_r_en, Output_SRAM_w_addr, Output_SRAM_r_addr,
           Output_SRAM_w_d,
    input  Output_SRAM_r_d, Output_SRAM_d_ready, Output_SRAM_w_done
  );

  modport slave (
    input  Output_SRAM_w_en, Output_SRAM_r_en, Output_SRAM_w_addr, Output_SRAM_r_addr,
           Output_SRAM_w_d,
    output Output_SRAM_r_d, Output_SRAM_d_ready, Output_SRAM_w_done
  );

endinterface

// File: rtl/delta_output_sram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_owner wins, wrapping to 0.
module delta_rr_picker #(
  parameter int REQ_NUM = 3,
  parameter int OWN_W   = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [OWN_W-1:0]   last_owner,
  output logic [REQ_NUM-1:0] winner,
  output logic               any_req
);

  logic found;

  // Pass one scans above last_owner; if nothing there, pass two takes the lowest index (wrap).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && req[i] && (i > int'(last_owner))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && req[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/delta_output_sram_arbiter.sv
// Round-robin arbiter sharing one Output SRAM port among REQ_NUM requesters, with a response watchdog.
module delta_output_sram_arbiter
  import delta_pkg::*;
#(
  parameter int REQ_NUM = REQ_NUM_DEF,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             req,
  input  logic [REQ_NUM-1:0]             req_we,
  input  logic [REQ_NUM-1:0][ADDR_W-1:0] req_addr,
  input  logic [REQ_NUM-1:0][DATA_W-1:0] req_wdata,
  output logic [REQ_NUM-1:0]             grant,
  output logic [REQ_NUM-1:0]             done,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  output logic                           timeout_err,
  delta_output_sram_arbiter_if.master    sram
);

  localparam int OWN_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [REQ_NUM-1:0]  winner;
  logic                any_req;
  logic [OWN_W-1:0]    win_idx;
  logic [OWN_W-1:0]    owner;
  logic [OWN_W-1:0]    last_owner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [WDOG_W-1:0]   wdog;
  logic                resp;
  logic                tmo;

  delta_rr_picker #(
    .REQ_NUM (REQ_NUM),
    .OWN_W   (OWN_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (winner[i]) win_idx = OWN_W'(i);
    end
  end

  // Only the response type matching the latched direction counts; the other one is ignored.
  assign resp = (state == ACCESS) &&
                (lat_we ? sram.Output_SRAM_w_done : sram.Output_SRAM_d_ready);
  assign tmo  = (state == ACCESS) && !resp && (wdog == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt                = state;
    sram.Output_SRAM_w_en    = 1'b0;
    sram.Output_SRAM_r_en    = 1'b0;
    sram.Output_SRAM_w_addr  = '0;
    sram.Output_SRAM_r_addr  = '0;
    sram.Output_SRAM_w_d     = '0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        sram.Output_SRAM_w_d = lat_wdata;
        if (lat_we) begin
          sram.Output_SRAM_w_en   = 1'b1;
          sram.Output_SRAM_w_addr = lat_addr;
        end else begin
          sram.Output_SRAM_r_en   = 1'b1;
          sram.Output_SRAM_r_addr = lat_addr;
        end
        if (resp || tmo) state_nxt = RELEASE;
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // done is raised on the edge that enters RELEASE, so it is visible exactly for the RELEASE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      done        <= '0;
      rdata       <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      owner       <= '0;
      last_owner  <= OWN_W'(REQ_NUM - 1);
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= winner;
            owner     <= win_idx;
            lat_we    <= req_we[win_idx];
            lat_addr  <= req_addr[win_idx];
            lat_wdata <= req_wdata[win_idx];
            wdog      <= '0;
          end
        end
        ACCESS: begin
          if (resp) begin
            done <= grant;
            if (!lat_we) rdata <= sram.Output_SRAM_r_d;
          end else if (tmo) begin
            done        <= grant;
            timeout_err <= 1'b1;
            rdata       <= '0;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        RELEASE: begin
          grant      <= '0;
          last_owner <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
